// File: rtl/tdm_pkg.sv
// Shared constants and types for the four-slot TDM demux.
// Slot count, slot index width and FSM states.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot counter for the TDM demux.
// Clear wins over load-1, which wins over increment.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  input  logic              ld1,
  input  logic              clr,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= '0;
    end else if (clr) begin
      slot <= '0;
    end else if (ld1) begin
      slot <= SLOT_W'(1);
    end else if (inc) begin
      slot <= slot + SLOT_W'(1);
    end
  end

  assign last = (slot == LAST_SLOT);

endmodule

// File: rtl/tdm_demux4.sv
// Four-slot TDM demultiplexer with frame hunt/lock.
// Publishes A-D together when the slot-3 sample lands.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic              in_valid,
  input  logic              frame,
  output logic [WIDTH-1:0]  a,
  output logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  c,
  output logic [WIDTH-1:0]  d,
  output logic              frame_done,
  output logic [SLOT_W-1:0] slot,
  output logic              locked,
  output logic              sync_err
);

  state_t state_q, state_d;

  logic inc, ld1, clr, last;
  logic wr0, wrs, pub, err;
  logic at0;

  logic [WIDTH-1:0] sh0, sh1, sh2;

  tdm_slot_ctr u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc),
    .ld1   (ld1),
    .clr   (clr),
    .slot  (slot),
    .last  (last)
  );

  assign at0 = (slot == '0);

  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    ld1     = 1'b0;
    clr     = 1'b0;
    wr0     = 1'b0;
    wrs     = 1'b0;
    pub     = 1'b0;
    err     = 1'b0;
    if (state_q == ST_HUNT) begin
      if (in_valid && frame) begin
        wr0     = 1'b1;
        ld1     = 1'b1;
        state_d = ST_LOCK;
      end
    end else if (in_valid) begin
      unique case (1'b1)
        frame && at0: begin
          wr0 = 1'b1;
          ld1 = 1'b1;
        end
        !frame && !at0: begin
          wrs = 1'b1;
          inc = 1'b1;
          pub = last;
        end
        // early marker: restart the frame here
        frame && !at0: begin
          err = 1'b1;
          wr0 = 1'b1;
          ld1 = 1'b1;
        end
        default: begin
          err     = 1'b1;
          clr     = 1'b1;
          state_d = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // slot 3 never lands in a shadow; it goes straight to d
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
    end else begin
      if (wr0) sh0 <= in;
      if (wrs && slot == 2'd1) sh1 <= in;
      if (wrs && slot == 2'd2) sh2 <= in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      b          <= '0;
      c          <= '0;
      d          <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      frame_done <= pub;
      sync_err   <= err;
      if (pub) begin
        a <= sh0;
        b <= sh1;
        c <= sh2;
        d <= in;
      end
    end
  end

  assign locked = (state_q == ST_LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4.
// Drives on negedge, samples 1ns after posedge.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in = '0;
  logic       in_valid = 1'b0;
  logic       frame = 1'b0;
  logic [7:0] a, b, c, d;
  logic       frame_done;
  logic [1:0] slot;
  logic       locked;
  logic       sync_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in         (in),
    .in_valid   (in_valid),
    .frame      (frame),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .frame_done (frame_done),
    .slot       (slot),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input logic f);
    @(negedge clk);
    in       = v;
    frame    = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    frame    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_abcd(input string tag, input logic [31:0] exp);
    chk({tag, ".abcd"}, {a, b, c, d}, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".abcd"}, {a, b, c, d}, 32'h0);
    chk({tag, ".fd"}, frame_done, 1'b0);
    chk({tag, ".slot"}, slot, 2'd0);
    chk({tag, ".lock"}, locked, 1'b0);
    chk({tag, ".err"}, sync_err, 1'b0);
  endtask

  initial begin
    logic [7:0] v;

    // reset state
    #1;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic frame
    send(8'h11, 1'b1);
    chk("t1.lock", locked, 1'b1);
    chk("t1.slot", slot, 2'd1);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    chk("t1.nofd", frame_done, 1'b0);
    send(8'h44, 1'b0);
    chk_abcd("t1", 32'h11223344);
    chk("t1.fd", frame_done, 1'b1);
    chk("t1.slot0", slot, 2'd0);
    chk("t1.err", sync_err, 1'b0);
    idle(1);
    chk("t1.fdpulse", frame_done, 1'b0);

    // 2: gapped frame
    send(8'h61, 1'b1);
    idle(3);
    send(8'h62, 1'b0);
    idle(3);
    send(8'h63, 1'b0);
    idle(3);
    chk_abcd("t2.hold", 32'h11223344);
    chk("t2.nofd", frame_done, 1'b0);
    send(8'h64, 1'b0);
    chk_abcd("t2", 32'h61626364);
    chk("t2.fd", frame_done, 1'b1);
    idle(1);
    chk("t2.fdpulse", frame_done, 1'b0);

    // 3: early frame marker
    send(8'hAA, 1'b1);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("t3.err", sync_err, 1'b1);
    chk("t3.lock", locked, 1'b1);
    chk("t3.slot", slot, 2'd1);
    chk_abcd("t3.hold", 32'h61626364);
    send(8'hDD, 1'b0);
    chk("t3.errpulse", sync_err, 1'b0);
    send(8'hEE, 1'b0);
    send(8'hFF, 1'b0);
    chk_abcd("t3", 32'hCCDDEEFF);
    chk("t3.fd", frame_done, 1'b1);

    // 4: missing marker
    send(8'h55, 1'b0);
    chk("t4.err", sync_err, 1'b1);
    chk("t4.lock", locked, 1'b0);
    chk("t4.slot", slot, 2'd0);
    chk("t4.nofd", frame_done, 1'b0);
    chk_abcd("t4.hold", 32'hCCDDEEFF);
    send(8'h56, 1'b0);
    chk("t4.huntnoerr", sync_err, 1'b0);
    chk("t4.huntlock", locked, 1'b0);
    send(8'h57, 1'b1);
    chk("t4.relock", locked, 1'b1);
    chk("t4.reslot", slot, 2'd1);
    send(8'h58, 1'b0);
    send(8'h59, 1'b0);
    send(8'h5A, 1'b0);
    chk_abcd("t4", 32'h5758595A);
    chk("t4.fd", frame_done, 1'b1);

    // reset during an in-flight frame_done pulse
    rst_n = 1'b0;
    #1;
    chk_zero("rstfd");
    @(negedge clk);
    rst_n = 1'b1;

    // 5: reset mid-frame
    send(8'h71, 1'b1);
    send(8'h72, 1'b0);
    send(8'h73, 1'b0);
    chk("t5.slot3", slot, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("t5.rst");
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h74, 1'b0);
    chk_zero("t5.post");
    idle(1);
    chk("t5.nofd", frame_done, 1'b0);

    // 6: eight full-rate frames
    send(8'h00, 1'b1);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 4; j++) begin
        v = 8'(8'h80 + 4 * k + j);
        send(v, j == 0);
        chk($sformatf("t6.fd%0d_%0d", k, j), frame_done, j == 3);
        chk($sformatf("t6.err%0d_%0d", k, j), sync_err, 1'b0);
      end
      v = 8'(8'h80 + 4 * k);
      chk_abcd($sformatf("t6.f%0d", k),
               {v, v + 8'd1, v + 8'd2, v + 8'd3});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
